// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, opcode constants and encodings for the RV32I pipeline control unit.
package ctrl_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] MTOREG_NONE  = 2'b00;
    localparam logic [1:0] MTOREG_ALU   = 2'b01;
    localparam logic [1:0] MTOREG_MEM   = 2'b10;
    localparam logic [1:0] MTOREG_UPPER = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       mr;
        logic       mwrite;
        logic       alusrc;
        logic       regwr;
        logic       jal;
        logic       jalr;
        logic       md;
        logic [1:0] aluop;
        logic [1:0] mtoreg;
    } ctrl_t;

    localparam int unsigned CTRL_W    = $bits(ctrl_t);
    localparam ctrl_t       CTRL_NONE = '0;

    typedef enum logic [0:0] {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    function automatic logic op_uses_rs2(input logic [4:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational RV32I instruction decoder producing the control bundle and an illegal flag.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter bit MD_EN = 1'b1
) (
    input  logic              valid_i,
    input  logic [31:0]       instr_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              uses_rs2_o,
    output logic              illegal_o
);

    ctrl_t      c;
    logic       known;
    logic [4:0] op;
    logic       is_md;

    assign op    = instr_i[6:2];
    assign is_md = (instr_i[31:25] == F7_MULDIV);

    always_comb begin
        c     = CTRL_NONE;
        known = 1'b1;
        case (op)
            OP_R: begin
                if (is_md && !MD_EN) begin
                    known = 1'b0;
                end else begin
                    c.regwr  = 1'b1;
                    c.aluop  = ALUOP_FUNCT;
                    c.mtoreg = MTOREG_ALU;
                    c.md     = is_md;
                end
            end
            OP_OPIMM: begin
                c.alusrc = 1'b1;
                c.regwr  = 1'b1;
                c.aluop  = ALUOP_FUNCT;
                c.mtoreg = MTOREG_ALU;
            end
            OP_LOAD: begin
                c.mr     = 1'b1;
                c.alusrc = 1'b1;
                c.regwr  = 1'b1;
                c.mtoreg = MTOREG_MEM;
            end
            OP_STORE: begin
                c.mwrite = 1'b1;
                c.alusrc = 1'b1;
            end
            OP_BRANCH: begin
                c.branch = 1'b1;
                c.aluop  = ALUOP_BRANCH;
            end
            OP_JAL: begin
                c.jal    = 1'b1;
                c.alusrc = 1'b1;
                c.regwr  = 1'b1;
                c.mtoreg = MTOREG_ALU;
            end
            OP_JALR: begin
                c.jalr   = 1'b1;
                c.alusrc = 1'b1;
                c.regwr  = 1'b1;
                c.mtoreg = MTOREG_ALU;
            end
            OP_AUIPC: begin
                c.alusrc = 1'b1;
                c.regwr  = 1'b1;
                c.aluop  = ALUOP_FUNCT;
                c.mtoreg = MTOREG_UPPER;
            end
            OP_LUI: begin
                c.alusrc = 1'b1;
                c.regwr  = 1'b1;
                c.mtoreg = MTOREG_UPPER;
            end
            default: known = 1'b0;
        endcase
        // Compressed/reserved encodings never decode.
        if (instr_i[1:0] != 2'b11) begin
            known = 1'b0;
        end
        if (!known) begin
            c = CTRL_NONE;
        end
    end

    assign ctrl_o     = c;
    assign uses_rs2_o = known & op_uses_rs2(op);
    assign illegal_o  = valid_i & ~known;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decode in ID, control registers for EX/MEM/WB, and the
// stall/flush/mul-div hold decisions.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned RA_W  = 5,
    parameter bit          MD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic              ex_redirect,
    input  logic              md_done,
    output logic              md_start,
    output logic              stall,
    output logic              flush,
    output logic              illegal,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [RA_W-1:0]   ex_rd,
    output logic [RA_W-1:0]   mem_rd,
    output logic [RA_W-1:0]   wb_rd,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid
);

    ctrl_t           dec_ctrl;
    logic            dec_uses_rs2;
    logic            dec_illegal;
    logic [RA_W-1:0] id_rd;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;

    ctrl_decoder #(
        .MD_EN(MD_EN)
    ) u_dec (
        .valid_i   (id_valid),
        .instr_i   (id_instr),
        .ctrl_o    (dec_ctrl),
        .uses_rs2_o(dec_uses_rs2),
        .illegal_o (dec_illegal)
    );

    assign id_rd  = RA_W'(id_instr[11:7]);
    assign id_rs1 = RA_W'(id_instr[19:15]);
    assign id_rs2 = RA_W'(id_instr[24:20]);

    md_state_t       md_state_q, md_state_d;
    logic            ex_valid_q, ex_valid_d;
    ctrl_t           ex_ctrl_q, ex_ctrl_d;
    logic [RA_W-1:0] ex_rd_q, ex_rd_d;
    logic            mem_valid_q, mem_valid_d;
    ctrl_t           mem_ctrl_q, mem_ctrl_d;
    logic [RA_W-1:0] mem_rd_q, mem_rd_d;
    logic            wb_valid_q, wb_valid_d;
    ctrl_t           wb_ctrl_q, wb_ctrl_d;
    logic [RA_W-1:0] wb_rd_q, wb_rd_d;

    logic load_use;
    logic stall_c, flush_c, md_start_c;
    logic id_ex_hold, id_ex_bubble, ex_mem_bubble;

    assign load_use = id_valid && ex_valid_q && ex_ctrl_q.mr && (ex_rd_q != '0) &&
                      ((ex_rd_q == id_rs1) || ((ex_rd_q == id_rs2) && dec_uses_rs2));

    always_comb begin
        md_state_d    = md_state_q;
        stall_c       = 1'b0;
        flush_c       = 1'b0;
        md_start_c    = 1'b0;
        id_ex_hold    = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if (ex_redirect) begin
            // Redirect outranks everything and abandons any mul/div wait.
            flush_c      = 1'b1;
            id_ex_bubble = 1'b1;
            md_state_d   = MD_IDLE;
        end else begin
            unique case (md_state_q)
                MD_IDLE: begin
                    if (ex_valid_q && ex_ctrl_q.md) begin
                        md_start_c    = 1'b1;
                        stall_c       = 1'b1;
                        id_ex_hold    = 1'b1;
                        ex_mem_bubble = 1'b1;
                        md_state_d    = MD_BUSY;
                    end else if (load_use) begin
                        stall_c      = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (md_done) begin
                        md_state_d = MD_IDLE;
                    end else begin
                        stall_c       = 1'b1;
                        id_ex_hold    = 1'b1;
                        ex_mem_bubble = 1'b1;
                    end
                end
                default: md_state_d = MD_IDLE;
            endcase
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_rd_d    = ex_rd_q;
        if (id_ex_bubble) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_NONE;
            ex_rd_d    = '0;
        end else if (!id_ex_hold) begin
            ex_valid_d = id_valid;
            ex_ctrl_d  = id_valid ? dec_ctrl : CTRL_NONE;
            ex_rd_d    = id_valid ? id_rd : '0;
        end

        mem_valid_d = ex_mem_bubble ? 1'b0 : ex_valid_q;
        mem_ctrl_d  = ex_mem_bubble ? CTRL_NONE : ex_ctrl_q;
        mem_rd_d    = ex_mem_bubble ? '0 : ex_rd_q;

        wb_valid_d = mem_valid_q;
        wb_ctrl_d  = mem_ctrl_q;
        wb_rd_d    = mem_rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state_q  <= MD_IDLE;
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= CTRL_NONE;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= CTRL_NONE;
            mem_rd_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= CTRL_NONE;
            wb_rd_q     <= '0;
        end else begin
            md_state_q  <= md_state_d;
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_rd_q    <= mem_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    // Control outputs stay quiet while reset is held, even with live ID/redirect inputs.
    assign stall    = stall_c & rst_n;
    assign flush    = flush_c & rst_n;
    assign md_start = md_start_c & rst_n;
    assign illegal  = dec_illegal & rst_n;

    assign ex_ctrl   = ex_ctrl_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign ex_rd     = ex_rd_q;
    assign mem_rd    = mem_rd_q;
    assign wb_rd     = wb_rd_q;
    assign ex_valid  = ex_valid_q;
    assign mem_valid = mem_valid_q;
    assign wb_valid  = wb_valid_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: load-use, mul/div hold, redirect, illegal decode and reset.
module tb_ctrl_pipe_unit;

    localparam int unsigned RA_W = 5;

    // Bundle order: branch mr mwrite alusrc regwr jal jalr md aluop[1:0] mtoreg[1:0]
    localparam logic [11:0] B_R    = 12'h089;
    localparam logic [11:0] B_MD   = 12'h099;
    localparam logic [11:0] B_IMM  = 12'h189;
    localparam logic [11:0] B_LOAD = 12'h582;
    localparam logic [11:0] B_BR   = 12'h804;
    localparam logic [11:0] B_LUI  = 12'h183;

    localparam logic [31:0] I_NOP    = 32'h00000013;
    localparam logic [31:0] I_LW_X5  = 32'h0000A283;
    localparam logic [31:0] I_ADD_X5 = 32'h00228333;
    localparam logic [31:0] I_LW_X0  = 32'h0000A003;
    localparam logic [31:0] I_ADD_X0 = 32'h00200333;
    localparam logic [31:0] I_MUL    = 32'h024183B3;
    localparam logic [31:0] I_BEQ    = 32'h00208463;
    localparam logic [31:0] I_LUI    = 32'h12345437;
    localparam logic [31:0] I_BAD    = 32'h0000007F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, ex_redirect, md_done, id2_valid;
    logic [31:0] id_instr, id2_instr;

    logic md_start, stall, flush, illegal, ex_valid, mem_valid, wb_valid;
    logic [11:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [RA_W-1:0] ex_rd, mem_rd, wb_rd;

    logic md_start2, stall2, flush2, illegal2, ex_valid2, mem_valid2, wb_valid2;
    logic [11:0] ex_ctrl2, mem_ctrl2, wb_ctrl2;
    logic [RA_W-1:0] ex_rd2, mem_rd2, wb_rd2;

    int n_total = 0;
    int n_bad = 0;
    int n_start, n_stall, n_bub;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.RA_W(RA_W), .MD_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_redirect(ex_redirect), .md_done(md_done), .md_start(md_start), .stall(stall),
        .flush(flush), .illegal(illegal), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
        .wb_ctrl(wb_ctrl), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid)
    );

    ctrl_pipe_unit #(.RA_W(RA_W), .MD_EN(1'b0)) u_dut_nomd (
        .clk(clk), .rst_n(rst_n), .id_valid(id2_valid), .id_instr(id2_instr),
        .ex_redirect(1'b0), .md_done(1'b0), .md_start(md_start2), .stall(stall2),
        .flush(flush2), .illegal(illegal2), .ex_ctrl(ex_ctrl2), .mem_ctrl(mem_ctrl2),
        .wb_ctrl(wb_ctrl2), .ex_rd(ex_rd2), .mem_rd(mem_rd2), .wb_rd(wb_rd2),
        .ex_valid(ex_valid2), .mem_valid(mem_valid2), .wb_valid(wb_valid2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        id_valid = 1'b0;
        id_instr = I_NOP;
        ex_redirect = 1'b0;
        md_done = 1'b0;
        id2_valid = 1'b0;
        id2_instr = I_NOP;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // lw x5 then dependent add: one stall, one bubble
        next_cyc(); id_valid = 1'b1; id_instr = I_LW_X5;
        @(negedge clk); check("lu_lw_id_stall", 32'(stall), 32'd0);
        next_cyc(); id_instr = I_ADD_X5;
        @(negedge clk);
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_ex_lw", 32'(ex_ctrl), 32'(B_LOAD));
        check("lu_ex_rd", 32'(ex_rd), 32'd5);
        next_cyc();
        @(negedge clk);
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_stall_once", 32'(stall), 32'd0);
        check("lu_mem_lw", 32'(mem_ctrl), 32'(B_LOAD));
        next_cyc(); id_instr = I_NOP;
        @(negedge clk);
        check("lu_add_valid", 32'(ex_valid), 32'd1);
        check("lu_add_ctrl", 32'(ex_ctrl), 32'(B_R));
        check("lu_add_rd", 32'(ex_rd), 32'd6);
        check("lu_wb_rd", 32'(wb_rd), 32'd5);

        // lw x0 never creates a hazard
        next_cyc(); id_instr = I_LW_X0;
        next_cyc(); id_instr = I_ADD_X0;
        @(negedge clk);
        check("x0_ex_load", 32'(ex_ctrl), 32'(B_LOAD));
        check("x0_no_stall", 32'(stall), 32'd0);
        next_cyc(); id_instr = I_NOP;
        @(negedge clk);
        check("x0_add_ctrl", 32'(ex_ctrl), 32'(B_R));

        // mul with md_done four cycles after md_start
        next_cyc(); id_instr = I_MUL;
        next_cyc(); id_instr = I_NOP;
        n_start = 0; n_stall = 0; n_bub = 0;
        for (int i = 0; i < 5; i++) begin
            md_done = (i == 4);
            @(negedge clk);
            n_start += int'(md_start);
            n_stall += int'(stall);
            n_bub += int'(!mem_valid);
            next_cyc();
        end
        md_done = 1'b0;
        @(negedge clk);
        check("md_start_once", 32'(n_start), 32'd1);
        check("md_stall_cycles", 32'(n_stall), 32'd4);
        check("md_mem_bubbles", 32'(n_bub), 32'd4);
        check("md_mem_ctrl", 32'(mem_ctrl), 32'(B_MD));
        check("md_mem_rd", 32'(mem_rd), 32'd7);
        check("md_ex_next", 32'(ex_ctrl), 32'(B_IMM));
        check("md_start_after", 32'(md_start), 32'd0);

        // md_done while idle is ignored
        next_cyc(); md_done = 1'b1;
        @(negedge clk); check("md_idle_done", 32'(stall), 32'd0);
        next_cyc(); md_done = 1'b0;

        // taken beq in EX while lui in ID
        id_instr = I_BEQ;
        next_cyc(); id_instr = I_LUI; ex_redirect = 1'b1;
        @(negedge clk);
        check("rd_flush", 32'(flush), 32'd1);
        check("rd_stall", 32'(stall), 32'd0);
        next_cyc(); ex_redirect = 1'b0; id_instr = I_LUI;
        @(negedge clk);
        check("rd_ex_bubble", 32'(ex_valid), 32'd0);
        check("rd_mem_beq", 32'(mem_ctrl), 32'(B_BR));
        check("rd_flush_once", 32'(flush), 32'd0);
        next_cyc(); id_instr = I_NOP;
        @(negedge clk); check("lui_ctrl", 32'(ex_ctrl), 32'(B_LUI));

        // illegal opcode, and mul on the MD_EN=0 instance
        next_cyc(); id_instr = I_BAD; id2_valid = 1'b1; id2_instr = I_MUL;
        @(negedge clk);
        check("ill_opcode", 32'(illegal), 32'd1);
        check("ill_nomd_mul", 32'(illegal2), 32'd1);
        next_cyc(); id_instr = I_NOP; id2_instr = I_NOP;
        @(negedge clk);
        check("ill_ex_zero", 32'(ex_ctrl), 32'd0);
        check("ill_nomd_zero", 32'(ex_ctrl2), 32'd0);
        check("ill_nop_legal", 32'(illegal), 32'd0);

        // reset with every stage full
        next_cyc(); next_cyc();
        @(negedge clk); check("pre_rst_wb", 32'(wb_valid), 32'd1);
        next_cyc(); rst_n = 1'b0; id_instr = I_BAD;
        @(negedge clk);
        check("mrst_ex_valid", 32'(ex_valid), 32'd0);
        check("mrst_mem_valid", 32'(mem_valid), 32'd0);
        check("mrst_wb_valid", 32'(wb_valid), 32'd0);
        check("mrst_wb_ctrl", 32'(wb_ctrl), 32'd0);
        check("mrst_illegal", 32'(illegal), 32'd0);
        next_cyc(); rst_n = 1'b1; id_instr = I_MUL;

        // reset while mul/div is busy abandons the op
        next_cyc(); id_instr = I_NOP;
        @(negedge clk); check("mrst_md_start", 32'(md_start), 32'd1);
        next_cyc(); rst_n = 1'b0;
        @(negedge clk); check("mrst_md_stall", 32'(stall), 32'd0);
        next_cyc(); rst_n = 1'b1;
        @(negedge clk); check("mrst_md_idle", 32'(stall), 32'd0);
        next_cyc();
        @(negedge clk);
        check("mrst_no_start", 32'(md_start), 32'd0);
        check("mrst_ex_nop", 32'(ex_ctrl), 32'(B_IMM));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined control unit for the RV32I pipeline: decodes the instruction in ID into a control bundle, carries the bundle through ID/EX, EX/MEM and MEM/WB registers, and owns pipeline-control decisions (load-use stall, redirect flush, multi-cycle mul/div hold). It replaces the single combinational decoder: datapath stage registers keep only data, and all control fields for EX, MEM and WB come from this block.

## Interface
- RA_W, 5, register-address width
- MD_EN, 1, 1 = M-extension ops (opcode 01100, funct7 0000001) decoded; 0 = flagged illegal
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_instr  in  32  instruction in ID
- ex_redirect  in  1  taken branch / jal / jalr resolved in EX this cycle
- md_done  in  1  mul/div unit result ready (one-cycle pulse)
- md_start  out  1  launch mul/div for EX op
- stall  out  1  hold PC and IF/ID
- flush  out  1  squash IF/ID
- illegal  out  1  ID instruction valid but undecodable
- ex_ctrl / mem_ctrl / wb_ctrl  out  bundle  registered control per stage
- ex_rd / mem_rd / wb_rd  out  RA_W  destination register per stage
- ex_valid / mem_valid / wb_valid  out  1  stage holds a real instruction

## Operation
- Bundle fields: branch, mr, mwrite, alusrc, regwr, jal, jalr, md, aluop[1:0], mtoreg[1:0].
- Decode on id_instr[6:2], requires id_instr[1:0]=11. R 01100: regwr, aluop 10, mtoreg 01. OP-IMM 00100: as R plus alusrc. Load 00000: mr, alusrc, regwr, mtoreg 10. Store 01000: mwrite, alusrc. Branch 11000: branch, aluop 01. JAL 11011 / JALR 11001: jal/jalr, alusrc, regwr, mtoreg 01. AUIPC 00101: alusrc, regwr, aluop 10, mtoreg 11. LUI 01101: alusrc, regwr, mtoreg 11. R with funct7 0000001 and MD_EN: R bundle plus md.
- No X outputs: unused fields drive 0. Unknown opcode: all-zero bundle, illegal=id_valid.
- Bubble = valid 0, all-zero bundle, rd 0.
- Load-use: ex_valid & ex_ctrl.mr & ex_rd!=0 & (ex_rd==rs1 | (ex_rd==rs2 & op uses rs2)) -> stall=1, bubble into ID/EX, one cycle.
- Redirect: ex_redirect -> flush=1, bubble into ID/EX; EX instruction advances normally.
- Mul/div FSM, states MD_IDLE, MD_BUSY:
  - MD_IDLE: ex_valid & ex_ctrl.md -> md_start=1, stall=1, ID/EX holds, bubble into EX/MEM, go MD_BUSY.
  - MD_BUSY: stall=1, ID/EX holds, bubble into EX/MEM until md_done; on md_done the md op advances to MEM, ID/EX loads next ID content, go MD_IDLE.
  - md_done in MD_IDLE ignored.
- Priority: redirect > md hold > load-use. Redirect and md op in EX cannot coincide (md op is not a control transfer); when they do, redirect wins and FSM returns to MD_IDLE.
- MEM/WB always advances; EX/MEM advances except bubbled as above.

## Timing
- Decode combinational in ID; ex_* valid 1 cycle after the ID cycle, mem_* +2, wb_* +3 absent stalls.
- stall, flush, md_start, illegal combinational from current-cycle inputs and registered state.
- md_start asserted exactly one cycle per md op.
- Reset (async assert, sync release): all valids 0, bundles 0, rd 0, FSM MD_IDLE, stall/flush/md_start/illegal 0. Reset mid-mul/div abandons the op; no md_start until a new md op reaches EX.

## Structure
- ctrl_pkg: opcode constants, ctrl_t bundle struct, aluop and mtoreg encodings, md_state_t enum.
- Sub-module ctrl_decoder: pure combinational instruction-to-ctrl_t plus illegal; top holds stage registers, hazard logic and FSM.

## Test plan
- Reset mid-stream: rst_n low 1 cycle with valid instructions in all stages -> all valids 0, stall 0, bundles 0 same cycle.
- lw x5,0(x1) followed by add x6,x5,x2 -> stall=1 one cycle, ex_valid=0 next cycle, add reaches EX one cycle late with regwr=1, aluop=10.
- lw x0,0(x1) then add x6,x0,x2 -> no stall.
- mul x7,x3,x4, md_done after 4 cycles -> md_start one cycle, stall 4 cycles, 4 mem bubbles, mul reaches mem_ctrl with md=1 the cycle after md_done.
- beq in EX with ex_redirect=1 while lui in ID -> flush=1, ex_valid=0 next cycle, beq advances to MEM with branch=1.
- MD_EN=0, mul in ID -> illegal=1, all-zero bundle; opcode 0x0000007F -> illegal=1.
